// File: rtl/complex_div_seq.sv
// rtl/complex_div_seq.sv - sequential complex divider y = a / b, packed {real, imag}; CDIV_ROUND_EN selects round-half-away rounding
module complex_div_seq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         div0
);
    localparam int W  = N / 2;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MUL, DIV, OUT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_q, b_q, den;
    // index 1 = real part, index 0 = imaginary part
    logic [1:0][N-1:0] mag, rem, mag_nx, rem_nx;
    logic [1:0]      neg, round_up;

    logic signed [W-1:0] ar, ai, br, bi;
    logic signed [N-1:0] p_rr, p_ii, p_ir, p_ri, p_br2, p_bi2;
    logic signed [N:0]   nr, ni;
    logic [N-1:0]        nr_mag, ni_mag, den_c;

    assign ar = a_q[N-1:W];
    assign ai = a_q[W-1:0];
    assign br = b_q[N-1:W];
    assign bi = b_q[W-1:0];

    assign p_rr  = ar * br;
    assign p_ii  = ai * bi;
    assign p_ir  = ai * br;
    assign p_ri  = ar * bi;
    assign p_br2 = br * br;
    assign p_bi2 = bi * bi;

    // num = a * conj(b); one extra bit since (-2^(W-1))^2 summed twice reaches 2^(N-1)
    assign nr     = {p_rr[N-1], p_rr} + {p_ii[N-1], p_ii};
    assign ni     = {p_ir[N-1], p_ir} - {p_ri[N-1], p_ri};
    assign den_c  = p_br2 + p_bi2;
    assign nr_mag = nr[N] ? (~nr[N-1:0] + 1'b1) : nr[N-1:0];
    assign ni_mag = ni[N] ? (~ni[N-1:0] + 1'b1) : ni[N-1:0];

    function automatic logic [2*N-1:0] div_step(input logic [N-1:0] r, input logic [N-1:0] m,
                                                input logic [N-1:0] d);
        logic [N:0] sh;
        sh = {r, m[N-1]};
        if (sh >= {1'b0, d})
            return {sh[N-1:0] - d, m[N-2:0], 1'b1};
        else
            return {sh[N-1:0], m[N-2:0], 1'b0};
    endfunction

    function automatic logic [W-1:0] sat_part(input logic [N-1:0] q, input logic up, input logic ng);
        logic [N:0] m;
        m = {1'b0, q} + {{N{1'b0}}, up};
        if (ng)
            return (m >= (N+1)'(1 << (W-1))) ? {1'b1, {(W-1){1'b0}}} : (~m[W-1:0] + 1'b1);
        else
            return (m > (N+1)'((1 << (W-1)) - 1)) ? {1'b0, {(W-1){1'b1}}} : m[W-1:0];
    endfunction

    assign {rem_nx[1], mag_nx[1]} = div_step(rem[1], mag[1], den);
    assign {rem_nx[0], mag_nx[0]} = div_step(rem[0], mag[0], den);

`ifdef CDIV_ROUND_EN
    assign round_up[1] = {rem_nx[1], 1'b0} >= {1'b0, den};
    assign round_up[0] = {rem_nx[0], 1'b0} >= {1'b0, den};
`else
    assign round_up = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            div0      <= 1'b0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            den       <= '0;
            mag       <= '0;
            rem       <= '0;
            neg       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    in_ready <= 1'b0;
                    state    <= MUL;
                end
                MUL: begin
                    den   <= den_c;
                    neg   <= {nr[N], ni[N]};
                    mag   <= {nr_mag, ni_mag};
                    rem   <= '0;
                    cnt   <= '0;
                    state <= DIV;
                end
                DIV: begin
                    mag <= mag_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        div0      <= (den == '0);
                        y         <= (den == '0) ? '0 :
                                     {sat_part(mag_nx[1], round_up[1], neg[1]),
                                      sat_part(mag_nx[0], round_up[0], neg[0])};
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_div_seq.sv
// tb/tb_complex_div_seq.sv - random and directed checks of complex_div_seq against an integer reference model
module tb_complex_div_seq;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, div0;
    logic [N-1:0] a, b, y;

    int n_cmp = 0;
    int n_bad = 0;

    complex_div_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qpart(input int n, input int d);
        int m, r, q;
        m = (n < 0 ? -n : n) / d;
        r = (n < 0 ? -n : n) % d;
`ifdef CDIV_ROUND_EN
        if (2 * r >= d) m++;
`endif
        q = (n < 0) ? -m : m;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // returns {div0, y}
    function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv);
        int ar, ai, br, bi, nr, ni, den, yr, yi;
        ar  = int'($signed(av[15:8]));
        ai  = int'($signed(av[7:0]));
        br  = int'($signed(bv[15:8]));
        bi  = int'($signed(bv[7:0]));
        den = br * br + bi * bi;
        if (den == 0) return {1'b1, 16'h0000};
        nr = ar * br + ai * bi;
        ni = ai * br - ar * bi;
        yr = qpart(nr, den);
        yi = qpart(ni, den);
        return {1'b0, yr[7:0], yi[7:0]};
    endfunction

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int hold,
                          output logic [15:0] yo);
        int lat;
        logic [16:0] exp;
        logic [15:0] y_hold;
        exp = model(av, bv);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat == 2) check("in_ready_busy", in_ready, 0);
            in_valid = 1'(($urandom & 1));
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 17);
        check("y", y, {16'h0, exp[15:0]});
        check("div0", div0, exp[16]);
        y_hold = y;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_y", y, y_hold);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        yo = y;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("consume_valid", out_valid, 0);
        check("consume_in_ready", in_ready, 1);
    endtask

    logic [15:0] yo;
    logic [15:0] ra, rb;
    logic [15:0] half_exp;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_div0", div0, 0);
        rst = 1'b0;

        run_op(16'h0608, 16'h0200, 0, yo);
        check("dir_6p8i_div_2", yo, 16'h0304);
        run_op(16'h0100, 16'h0001, 0, yo);
        check("dir_1_div_i", yo, 16'h00FF);
`ifdef CDIV_ROUND_EN
        half_exp = 16'h0100;
`else
        half_exp = 16'h0000;
`endif
        run_op(16'h0100, 16'h0200, 1, yo);
        check("dir_half", yo, half_exp);
        run_op(16'h8000, 16'hFF00, 0, yo);
        check("dir_sat", yo, 16'h7F00);
        run_op(16'h1234, 16'h0000, 10, yo);
        check("dir_div0", yo, 16'h0000);

        // reset in the middle of the divide discards the operation
        @(negedge clk);
        a = 16'h0608; b = 16'h0200; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_y", y, 0);
        run_op(16'h0608, 16'h0200, 0, yo);
        check("after_rst", yo, 16'h0304);

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb[15:4] = '0;
            run_op(ra, rb, $urandom_range(0, 3), yo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
